// File: rtl/dds_pkg.sv
// Shared definitions for the DDS-to-DAC serial path: frame layout and transmitter states.
package dds_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned PAD_HI     = 4;
    localparam int unsigned PAD_LO     = 4;
    localparam int unsigned DATA_BITS  = FRAME_BITS - PAD_HI - PAD_LO;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StShift,
        StHold
    } tx_state_e;

    // 8-bit sample lands in the top of the 10-bit DAC code, so the two fill bits read as zero.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] sample);
        return {{PAD_HI{1'b0}}, sample, {PAD_LO{1'b0}}};
    endfunction

endpackage

// File: rtl/clk_div_tick.sv
// Free-running modulo-COUNT counter emitting a one-cycle tick on its terminal count.
module clk_div_tick #(
    parameter int unsigned COUNT = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned W = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [W-1:0] count_q, count_d;

    always_comb begin
        tick_o  = (count_q == W'(COUNT - 1));
        count_d = (clr_i || tick_o) ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises one DDS sample per sample tick into a 16-bit SPI write to the DAC.
module dac_spi_tx
    import dds_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned SAMPLE_DIV = 100
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 dac_cs_n,
    output logic                 dac_sclk,
    output logic                 dac_din,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun
);

    // Half-period index 2*FRAME_BITS is the extra low phase before chip select releases.
    localparam int unsigned HALF_LAST = 2 * FRAME_BITS;
    localparam int unsigned HW        = $clog2(HALF_LAST + 1);

    tx_state_e             state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [HW-1:0]         half_q, half_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic                  din_q, din_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovr_q, ovr_d;
    logic                  sample_tick, phase_tick, phase_clr;

    assign phase_clr = (state_q == StIdle);

    clk_div_tick #(
        .COUNT(SAMPLE_DIV)
    ) u_sample_div (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .clr_i (1'b0),
        .tick_o(sample_tick)
    );

    // Held in reset while idle so every frame's first phase is a full CLK_DIV long.
    clk_div_tick #(
        .COUNT(CLK_DIV)
    ) u_phase_div (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .clr_i (phase_clr),
        .tick_o(phase_tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        half_d  = half_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        din_d   = din_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q | (sample_tick & (state_q != StIdle));

        unique case (state_q)
            StIdle: begin
                if (sample_tick && enable) begin
                    state_d = StSetup;
                    shift_d = build_frame(data_in);
                    half_d  = '0;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    din_d   = shift_d[FRAME_BITS-1];
                    busy_d  = 1'b1;
                end
            end
            StSetup: begin
                if (phase_tick) begin
                    state_d = StShift;
                    sclk_d  = 1'b1;
                end
            end
            StShift: begin
                if (phase_tick) begin
                    if (half_q == HW'(HALF_LAST)) begin
                        state_d = StHold;
                        shift_d = '0;
                        cs_n_d  = 1'b1;
                        din_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        half_d = half_q + 1'b1;
                        sclk_d = ~half_d[0] && (half_d != HW'(HALF_LAST));
                        // Data moves only on falling edges so it is stable at the DAC's rising edge.
                        if (sclk_q) begin
                            shift_d = shift_q << 1;
                            din_d   = shift_d[FRAME_BITS-1];
                        end
                    end
                end
            end
            StHold: begin
                if (phase_tick) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            half_q  <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            half_q  <= half_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_din    = din_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Three configurations of dac_spi_tx driven in parallel, checked every cycle against a timeline model.
module tb_dac_spi_tx;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] data;
    logic [2:0] cs_n, sclk, din, busy, fd, ovr;

    int cd [3] = '{2, 2, 1};
    int sd [3] = '{100, 40, 37};

    int vectors     = 0;
    int miscompares = 0;

    // Model: cycles elapsed since capture (0 = idle), sample counter, captured frame, overrun.
    int          m_k   [3];
    int          m_cnt [3];
    logic [15:0] m_frame [3];
    logic        m_ovr [3];
    bit          m_valid = 0;

    // Per-frame statistics gathered from the DUT pins.
    logic [15:0] rec_word [3];
    logic [15:0] last_word [3];
    int          rec_busy [3], rec_edges [3], rec_done [3];
    int          last_busy [3], last_edges [3], last_done [3];
    int          frames [3];
    logic        prev_busy [3], prev_sclk [3];

    int          req = 0, ack = 0;
    int          chk_inst, chk_busy, chk_edges;
    logic [15:0] chk_word;
    logic        chk_ovr;
    bit          chk_tmo;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dac_spi_tx #(.CLK_DIV(2), .SAMPLE_DIV(100)) u_dut0 (
        .sys_clk(clk), .sys_rst(rst), .enable(en), .data_in(data),
        .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]), .dac_din(din[0]),
        .busy(busy[0]), .frame_done(fd[0]), .overrun(ovr[0])
    );

    dac_spi_tx #(.CLK_DIV(2), .SAMPLE_DIV(40)) u_dut1 (
        .sys_clk(clk), .sys_rst(rst), .enable(en), .data_in(data),
        .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]), .dac_din(din[1]),
        .busy(busy[1]), .frame_done(fd[1]), .overrun(ovr[1])
    );

    dac_spi_tx #(.CLK_DIV(1), .SAMPLE_DIV(37)) u_dut2 (
        .sys_clk(clk), .sys_rst(rst), .enable(en), .data_in(data),
        .dac_cs_n(cs_n[2]), .dac_sclk(sclk[2]), .dac_din(din[2]),
        .busy(busy[2]), .frame_done(fd[2]), .overrun(ovr[2])
    );

    // Expected {cs_n, sclk, din, busy, frame_done} k cycles after capture.
    function automatic logic [4:0] exp_pins(input int k, input int d, input logic [15:0] f);
        int   h, j, idx;
        logic dn;
        if (k == 0) return 5'b10000;
        h = (k - 1) / d;
        if (h == 0) return {1'b0, 1'b0, f[15], 1'b1, 1'b0};
        if (h >= 34) return {1'b1, 1'b0, 1'b0, 1'b1, (k == 34 * d + 1)};
        j   = h - 1;
        idx = 15 - (j + 1) / 2;
        dn  = (idx >= 0) ? f[idx] : 1'b0;
        return {1'b0, (j < 32 && j % 2 == 0), dn, 1'b1, 1'b0};
    endfunction

    task automatic cmp(input string name, input int i, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s inst%0d got %0h want %0h", name, i, got, want);
        end
    endtask

    // Single compare process: pin check, frame statistics, literal requests, then model advance.
    initial begin
        logic [5:0] got, want;
        bit         tk;
        int         cyc;
        int         i;
        cyc = 0;
        for (int n = 0; n < 3; n++) begin
            frames[n] = 0; prev_busy[n] = 1'b0; prev_sclk[n] = 1'b0;
            rec_word[n] = '0; rec_busy[n] = 0; rec_edges[n] = 0; rec_done[n] = 0;
            last_word[n] = '0; last_busy[n] = 0; last_edges[n] = 0; last_done[n] = 0;
        end
        forever begin
            @(negedge clk);
            for (int n = 0; n < 3; n++) begin
                if (m_valid) begin
                    got  = {cs_n[n], sclk[n], din[n], busy[n], fd[n], ovr[n]};
                    want = {exp_pins(m_k[n], cd[n], m_frame[n]), m_ovr[n]};
                    vectors++;
                    if (got !== want) begin
                        miscompares++;
                        $display("FAIL pins inst%0d cycle %0d {cs_n,sclk,din,busy,done,ovr} got %b want %b",
                                 n, cyc, got, want);
                    end
                end
                if (busy[n] === 1'b1 && !prev_busy[n]) begin
                    rec_word[n] = '0; rec_busy[n] = 0; rec_edges[n] = 0; rec_done[n] = 0;
                end
                if (busy[n] === 1'b1) rec_busy[n]++;
                if (sclk[n] === 1'b1 && !prev_sclk[n] && cs_n[n] === 1'b0) begin
                    rec_word[n] = {rec_word[n][14:0], din[n]};
                    rec_edges[n]++;
                end
                if (fd[n] === 1'b1) rec_done[n]++;
                if (busy[n] === 1'b0 && prev_busy[n] && rec_done[n] > 0) begin
                    last_word[n]  = rec_word[n];
                    last_busy[n]  = rec_busy[n];
                    last_edges[n] = rec_edges[n];
                    last_done[n]  = rec_done[n];
                    frames[n]++;
                end
                prev_busy[n] = (busy[n] === 1'b1);
                prev_sclk[n] = (sclk[n] === 1'b1);
            end

            if (req != ack) begin
                i = chk_inst;
                if (chk_tmo) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL wait_timeout inst%0d frames %0d", i, frames[i]);
                end else begin
                    cmp("frame_word", i, int'(last_word[i]), int'(chk_word));
                    cmp("busy_cycles", i, last_busy[i], chk_busy);
                    cmp("rising_edges", i, last_edges[i], chk_edges);
                    cmp("done_pulses", i, last_done[i], 1);
                    cmp("overrun", i, int'(ovr[i]), int'(chk_ovr));
                end
                ack = req;
            end

            // Inputs are stable from posedge+1 until the next posedge, so they predict that edge.
            for (int n = 0; n < 3; n++) begin
                tk = (m_cnt[n] == sd[n] - 1);
                if (rst) begin
                    m_cnt[n] = 0; m_k[n] = 0; m_ovr[n] = 1'b0; m_frame[n] = '0;
                end else begin
                    m_cnt[n] = tk ? 0 : m_cnt[n] + 1;
                    if (m_k[n] != 0) begin
                        if (tk) m_ovr[n] = 1'b1;
                        m_k[n] = (m_k[n] == 35 * cd[n]) ? 0 : m_k[n] + 1;
                    end else if (tk && en) begin
                        m_frame[n] = 16'(data) << 4;
                        m_k[n]     = 1;
                    end
                end
            end
            m_valid = 1;
            cyc++;
        end
    end

    task automatic check(input int i, input logic [15:0] w, input int b, input int e,
                         input logic o, input bit tmo);
        chk_inst = i; chk_word = w; chk_busy = b; chk_edges = e; chk_ovr = o; chk_tmo = tmo;
        req++;
        repeat (3) @(posedge clk);
        if (ack != req) begin
            $display("FAIL check_handshake ack %0d want %0d", ack, req);
            $fatal(1, "compare process stalled");
        end
        #1;
    endtask

    task automatic wait_frames(input int i, input int n, input int budget, output bit tmo);
        tmo = 1'b1;
        for (int c = 0; c < budget && tmo; c++) begin
            @(posedge clk); #1;
            if (frames[i] >= n) tmo = 1'b0;
        end
    endtask

    task automatic wait_busy_rise(input int i, input int budget, output bit tmo);
        logic prev;
        prev = busy[i];
        tmo  = 1'b1;
        for (int c = 0; c < budget && tmo; c++) begin
            @(posedge clk); #1;
            if (busy[i] && !prev) tmo = 1'b0;
            prev = busy[i];
        end
    endtask

    initial begin
        bit   tmo, tmo2;
        int   base, rises;
        logic prev;
        rst = 1'b1; en = 1'b1; data = 8'hA5;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Default config, A5: 0A50, 70 busy cycles; SAMPLE_DIV=40 overruns; CLK_DIV=1 frames are 35.
        wait_frames(0, 1, 400, tmo);
        check(0, 16'h0A50, 70, 16, 1'b0, tmo);
        check(1, 16'h0A50, 70, 16, 1'b1, 1'b0);
        check(2, 16'h0A50, 35, 16, 1'b0, 1'b0);

        // Data changing two cycles after capture must not reach the frame in flight.
        data = 8'h00;
        wait_busy_rise(0, 200, tmo);
        @(posedge clk); #1 data = 8'hFF;
        base = frames[0];
        wait_frames(0, base + 1, 200, tmo2);
        check(0, 16'h0000, 70, 16, 1'b0, tmo | tmo2);
        wait_frames(0, base + 2, 200, tmo);
        check(0, 16'h0FF0, 70, 16, 1'b0, tmo);

        // Reset at the 7th rising sclk edge aborts the frame; the next one is whole.
        data = 8'h3C;
        wait_busy_rise(0, 200, tmo);
        rises = 0;
        prev  = sclk[0];
        for (int c = 0; c < 200 && rises < 7; c++) begin
            @(posedge clk); #1;
            if (sclk[0] && !prev) rises++;
            prev = sclk[0];
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        base = frames[0];
        wait_frames(0, base + 1, 300, tmo2);
        check(0, 16'h03C0, 70, 16, 1'b0, tmo | tmo2 | (rises != 7));

        // Disabled for more than three sample periods, then re-enabled.
        en = 1'b0;
        repeat (350) @(posedge clk);
        #1 en = 1'b1;
        base = frames[0];
        wait_frames(0, base + 1, 250, tmo);
        check(0, 16'h03C0, 70, 16, 1'b0, tmo);

        // Random data every cycle with occasional enable toggles and reset pulses.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            data = 8'($urandom);
            if ($urandom_range(0, 399) == 0) en = ~en;
            rst = ($urandom_range(0, 699) == 0);
        end
        rst = 1'b0; en = 1'b1; data = 8'h80;

        // CLK_DIV=1 back-to-back frames carrying 0800 with no overrun.
        base = frames[2];
        wait_frames(2, base + 2, 200, tmo);
        check(2, 16'h0800, 35, 16, 1'b0, tmo);
        base = frames[0];
        wait_frames(0, base + 2, 400, tmo);
        check(0, 16'h0800, 70, 16, 1'b0, tmo);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
